adder_subtractor_sequencer: RTL and testbench

- Initiator side of the FP adder/subtractor interface.
- Accepts a job of N operand pairs from the upstream cluster logic, issues one pair per cycle into the adder_subtractor_with_start datapath, and drives its ce, op, start and outsider15 controls.
- Tracks the adder pipeline latency, captures each returned result and reports job completion.
- Sits between the Jacobi cluster organizer and each adder instance.

---
 rtl/adder_subtractor_sequencer.sv | 144 ++++++++++++++
 tb/tb_adder_subtractor_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_subtractor_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adder_subtractor_sequencer
// Description : Initiator for the FP adder/subtractor datapath. Accepts a job
//               of N operand pairs, issues one pair per cycle, tracks the
//               adder latency with a valid pipe, captures each result and
//               pulses done when the whole job has been collected.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_subtractor_sequencer #(
  parameter int LATENCY = 5,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_start,
  input  logic [LEN_W-1:0] job_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_op,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_op,
  output logic             add_ce,
  output logic             add_start,
  output logic             add_outsider15,
  input  logic [31:0]      add_result,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [LEN_W-1:0]   job_len_q;
  logic [LEN_W-1:0]   issued;
  logic [LEN_W-1:0]   collected;
  logic [LATENCY-1:0] vpipe;
  logic               hs;

  // Control outputs are pure decodes of the state; the adder only runs while
  // operations are in flight, so ce and start share the same qualifier.
  always_comb begin
    in_ready  = (state == S_RUN);
    add_ce    = (state == S_RUN) || (state == S_DRAIN);
    add_start = (state == S_RUN) || (state == S_DRAIN);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    hs        = in_valid && (state == S_RUN);
  end

  // The oldest slot of the valid pipe marks the cycle the adder output is live.
  assign add_outsider15 = vpipe[LATENCY-1];

  generate
    if (LATENCY == 1) begin : g_pipe_single
      // Single-slot valid pipe: the handshake itself is the only stage.
      always_ff @(posedge clk) begin
        if (!rst) vpipe <= '0;
        else      vpipe <= hs;
      end
    end else begin : g_pipe_shift
      // Valid pipe: a 1 enters on each handshake, a 0 on every bubble.
      always_ff @(posedge clk) begin
        if (!rst) vpipe <= '0;
        else      vpipe <= {vpipe[LATENCY-2:0], hs};
      end
    end
  endgenerate

  // Job control: sequencing through IDLE/RUN/DRAIN/DONE with issue and
  // collection counters; collected only moves while results can return.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      job_len_q <= '0;
      issued    <= '0;
      collected <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_start) begin
            if (job_len == '0) begin
              state <= S_DONE;
            end else begin
              job_len_q <= job_len;
              issued    <= '0;
              collected <= '0;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (hs) begin
            issued <= issued + ONE;
            if (issued == job_len_q - ONE) state <= S_DRAIN;
          end
          if (add_outsider15) collected <= collected + ONE;
        end
        S_DRAIN: begin
          if (add_outsider15) collected <= collected + ONE;
          if (collected == job_len_q) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Issue and capture registers: operands load on handshake, the result is
  // sampled on the strobe so res_valid trails add_outsider15 by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      add_a     <= '0;
      add_b     <= '0;
      add_op    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (hs) begin
        add_a  <= in_a;
        add_b  <= in_b;
        add_op <= in_op;
      end
      res_valid <= add_outsider15;
      if (add_outsider15) res_data <= add_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_subtractor_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_subtractor_sequencer
// Description : Self-checking bench for adder_subtractor_sequencer with a
//               behavioural adder stub and a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_subtractor_sequencer;

  localparam int L  = 5;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_start;
  logic [LW-1:0] job_len;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a, in_b;
  logic          in_op;
  logic [31:0]   add_a, add_b;
  logic          add_op, add_ce, add_start, add_outsider15;
  logic [31:0]   add_result;
  logic          res_valid;
  logic [31:0]   res_data;
  logic          busy, done;

  adder_subtractor_sequencer #(.LATENCY(L), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .add_a(add_a), .add_b(add_b), .add_op(add_op),
    .add_ce(add_ce), .add_start(add_start), .add_outsider15(add_outsider15),
    .add_result(add_result), .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // FP helpers: single <-> double through real arithmetic (truncating).
  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return $bitstoreal({x[31], 63'd0});
    e = {3'd0, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] b;
    logic [10:0] e;
    logic [10:0] se;
    b = $realtobits(r);
    e = b[62:52];
    if (e <= 11'd896) return {b[63], 31'd0};
    if (e >= 11'd1151) return {b[63], 8'hFF, 23'd0};
    se = e - 11'd896;
    return {b[63], se[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] fp_addsub(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
    real ra, rb;
    ra = sp2r(a);
    rb = sp2r(b);
    return r2sp(op ? (ra - rb) : (ra + rb));
  endfunction

  // Adder stub: operands delayed so the result is live exactly when the
  // sequencer's strobe fires for that pair.
  logic [31:0] pa [L-1];
  logic [31:0] pb [L-1];
  logic        po [L-1];
  always @(posedge clk) begin
    pa[0] <= add_a; pb[0] <= add_b; po[0] <= add_op;
    for (int i = 1; i < L-1; i++) begin
      pa[i] <= pa[i-1]; pb[i] <= pb[i-1]; po[i] <= po[i-1];
    end
  end
  assign add_result = fp_addsub(pa[L-2], pb[L-2], po[L-2]);

  // Reference model state
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          m_active = 1'b0;
  int          m_to_issue = 0;
  int          m_out = 0;
  int          m_done_cycle = -1;
  int          done_seen = 0;
  logic [31:0] rv_due [int];
  bit          os_due [int];
  logic [31:0] got_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Check this cycle's outputs against the model, then advance the model
  // with this cycle's inputs.
  task automatic monitor();
    logic e_ready, e_done, e_busy, e_os, e_rv;
    cyc++;
    if (!mon_en) return;
    e_ready = m_active && (m_to_issue > 0);
    e_done  = (m_done_cycle == cyc);
    e_busy  = m_active || e_done;
    e_os    = os_due.exists(cyc);
    e_rv    = rv_due.exists(cyc);
    chk("in_ready", in_ready, e_ready);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("add_ce", add_ce, m_active);
    chk("add_start", add_start, m_active);
    chk("add_outsider15", add_outsider15, e_os);
    chk("res_valid", res_valid, e_rv);
    if (e_rv) chk("res_data", res_data, rv_due[cyc]);
    if (res_valid === 1'b1) got_q.push_back(res_data);
    if (done === 1'b1) done_seen++;
    if (e_rv) begin
      rv_due.delete(cyc);
      m_out--;
    end
    if (e_os) os_due.delete(cyc);
    if (rst === 1'b0) begin
      m_active = 1'b0; m_to_issue = 0; m_out = 0; m_done_cycle = -1;
      rv_due.delete();
      os_due.delete();
    end else begin
      if (e_ready && in_valid) begin
        rv_due[cyc+L+1] = fp_addsub(in_a, in_b, in_op);
        os_due[cyc+L]   = 1'b1;
        m_to_issue--;
        m_out++;
      end
      if (m_active && m_to_issue == 0 && m_out == 0) begin
        m_active     = 1'b0;
        m_done_cycle = cyc + 1;
      end
      if (job_start && !e_busy) begin
        if (job_len == '0) m_done_cycle = cyc + 1;
        else begin
          m_active   = 1'b1;
          m_to_issue = int'(job_len);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    in_valid  = 1'b0;
    job_len   = LW'(len);
    job_start = 1'b1;
    step();
    job_start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input int gap);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    do begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = $urandom; in_b = $urandom; in_op = 1'($urandom);
      step();
      k++;
    end while (busy !== 1'b0 && k < max);
    in_valid = 1'b0;
    chk("idle_timeout", busy, 1'b0);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(100, 150));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int len;
    rst = 1'b0; job_start = 1'b0; job_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_op = 1'b0;
    step(); step();
    mon_en = 1'b1;
    step();
    chk("reset add_a", add_a, 32'h0);
    chk("reset res_data", res_data, 32'h0);
    chk("reset add_ce", add_ce, 1'b0);
    rst = 1'b1;
    step();

    // Single add
    got_q.delete(); d0 = done_seen;
    start_job(1);
    feed(32'h3F800000, 32'h40000000, 1'b0, 0);
    wait_idle(40);
    chk("single res_data", res_data, 32'h40400000);
    chk("single done count", done_seen - d0, 1);
    chk("single result count", got_q.size(), 1);

    // Back-to-back mixed job
    got_q.delete();
    start_job(3);
    feed(32'h40400000, 32'h3F800000, 1'b1, 0);
    feed(32'h3F800000, 32'h3F800000, 1'b0, 0);
    feed(32'h80000000, 32'h00000000, 1'b0, 0);
    wait_idle(40);
    chk("b2b count", got_q.size(), 3);
    chk("b2b r0", got_q[0], 32'h40000000);
    chk("b2b r1", got_q[1], 32'h40000000);
    chk("b2b r2", got_q[2], 32'h00000000);

    // Bubbles on alternate cycles
    got_q.delete(); d0 = done_seen;
    start_job(4);
    for (int i = 0; i < 4; i++) feed(rnd_fp(), rnd_fp(), 1'($urandom), 1);
    wait_idle(40);
    chk("bubble count", got_q.size(), 4);
    chk("bubble done count", done_seen - d0, 1);

    // Zero-length job
    d0 = done_seen;
    start_job(0);
    wait_idle(10);
    chk("zero done count", done_seen - d0, 1);

    // Reset mid-job during DRAIN with two results outstanding
    d0 = done_seen;
    start_job(3);
    for (int i = 0; i < 3; i++) feed(rnd_fp(), rnd_fp(), 1'($urandom), 0);
    repeat (3) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst busy", busy, 1'b0);
    chk("rst add_ce", add_ce, 1'b0);
    chk("rst res_valid", res_valid, 1'b0);
    repeat (8) step();
    chk("rst no done", done_seen - d0, 0);
    got_q.delete();
    start_job(1);
    feed(32'h3F800000, 32'h3F800000, 1'b0, 0);
    wait_idle(40);
    chk("post-rst result", res_data, 32'h40000000);
    chk("post-rst done", done_seen - d0, 1);

    // job_start pulsed during RUN is ignored
    got_q.delete(); d0 = done_seen;
    start_job(4);
    feed(rnd_fp(), rnd_fp(), 1'b0, 0);
    job_start = 1'b1; job_len = '0;
    feed(rnd_fp(), rnd_fp(), 1'b1, 0);
    job_start = 1'b0; job_len = 16'd9;
    feed(rnd_fp(), rnd_fp(), 1'b0, 1);
    feed(rnd_fp(), rnd_fp(), 1'b1, 0);
    wait_idle(40);
    chk("ignore start count", got_q.size(), 4);
    chk("ignore start done", done_seen - d0, 1);

    // Randomized jobs
    for (int j = 0; j < 12; j++) begin
      len = $urandom_range(1, 8);
      got_q.delete(); d0 = done_seen;
      start_job(len);
      for (int i = 0; i < len; i++) begin
        job_start = ($urandom_range(0, 3) == 0);
        job_len   = LW'($urandom_range(0, 20));
        feed(rnd_fp(), rnd_fp(), 1'($urandom), $urandom_range(0, 2));
      end
      job_start = 1'b0;
      wait_idle(60);
      chk("rand count", got_q.size(), len);
      chk("rand done", done_seen - d0, 1);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
